// File: rtl/ieee_conv_pkg.sv
// Shared types and constants for the ASCII-to-IEEE-754 converter front end.
// Holds the parser state encoding, character codes and R/P sizing helper.
package ieee_conv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT,
        S_FRAC,
        S_DRAIN,
        S_CONV,
        S_OUT
    } state_e;

    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_NINE  = 8'h39;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // 10^n < 2^(4n+1), so R, P and 2R all fit
    function automatic int rp_width(input int digits);
        return 4 * digits + 1;
    endfunction

endpackage

// File: rtl/frac_radix_converter.sv
// Accumulates decimal fraction digits as R/P and converts them to a binary
// fraction by serial restoring division, one bit per cycle.
module frac_radix_converter
    import ieee_conv_pkg::*;
#(
    parameter int fra_len         = 8,
    parameter int max_frac_digits = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               zero_r_i,
    input  logic               acc_i,
    input  logic [3:0]         digit_i,
    input  logic               start_i,
    output logic               full_o,
    output logic               done_o,
    output logic [fra_len-1:0] frac_o
);

    localparam int W  = rp_width(max_frac_digits);
    localparam int NW = $clog2(max_frac_digits + 1);
    localparam int CW = $clog2(fra_len + 1);

    logic [W-1:0]       r_q, r_d, p_q, p_d;
    logic [NW-1:0]      ndig_q, ndig_d;
    logic [fra_len-1:0] frac_q, frac_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [W:0]         t, diff;
    logic               take;

    assign t      = {r_q, 1'b0};
    assign diff   = t - {1'b0, p_q};
    assign take   = t >= {1'b0, p_q};
    assign full_o = ndig_q == NW'(max_frac_digits);
    assign done_o = busy_q && (cnt_q == CW'(fra_len - 1));
    assign frac_o = frac_q;

    always_comb begin
        r_d    = r_q;
        p_d    = p_q;
        ndig_d = ndig_q;
        frac_d = frac_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (clear_i) begin
            r_d    = '0;
            p_d    = W'(1);
            ndig_d = '0;
            frac_d = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (zero_r_i) begin
            r_d = '0;
        end else if (acc_i) begin
            // digits past the retained count are truncated
            if (!full_o) begin
                r_d    = r_q * W'(10) + W'(digit_i);
                p_d    = p_q * W'(10);
                ndig_d = ndig_q + 1'b1;
            end
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            frac_d = '0;
        end else if (busy_q) begin
            frac_d = (frac_q << 1) | fra_len'(take);
            r_d    = take ? diff[W-1:0] : t[W-1:0];
            cnt_d  = cnt_q + 1'b1;
            if (done_o) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            p_q    <= W'(1);
            ndig_q <= '0;
            frac_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            p_q    <= p_d;
            ndig_q <= ndig_d;
            frac_q <= frac_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/ascii_fixed_point_parser.sv
// Byte-serial ASCII decimal parser producing integer, binary fraction and
// sign fields for the IEEE-754 converter, with valid/ready on both sides.
module ascii_fixed_point_parser
    import ieee_conv_pkg::*;
#(
    parameter int int_len         = 8,
    parameter int fra_len         = 8,
    parameter int max_frac_digits = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [int_len-1:0] o_integer,
    output logic [fra_len-1:0] o_fraction,
    output logic               o_sign,
    output logic               o_error
);

    localparam int PW = int_len + 4;

    state_e             state_q, state_d;
    logic [int_len-1:0] int_q, int_d;
    logic               sign_q, sign_d, ovf_q, ovf_d, err_q, err_d;
    logic               xfer, hs;
    logic               is_digit, is_term, is_minus, is_dot;
    logic [PW-1:0]      prod;
    logic               prod_ovf;
    logic               conv_start, frac_acc, zero_r, conv_done, frac_full;

    assign xfer     = in_valid & in_ready;
    assign hs       = o_valid & o_ready;
    assign is_digit = (in_data >= CH_ZERO) && (in_data <= CH_NINE);
    assign is_term  = (in_data == CH_LF) || (in_data == CH_SPACE);
    assign is_minus = in_data == CH_MINUS;
    assign is_dot   = in_data == CH_DOT;
    assign prod     = PW'(int_q) * PW'(10) + PW'(in_data[3:0]);
    assign prod_ovf = |prod[PW-1:int_len];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (xfer && !is_term) begin
                if (is_minus || is_digit) state_d = S_INT;
                else if (is_dot)          state_d = S_FRAC;
                else                      state_d = S_DRAIN;
            end
            S_INT: if (xfer) begin
                if (is_dot)         state_d = S_FRAC;
                else if (is_term)   state_d = S_CONV;
                else if (!is_digit) state_d = S_DRAIN;
            end
            S_FRAC: if (xfer) begin
                if (is_term)        state_d = S_CONV;
                else if (!is_digit) state_d = S_DRAIN;
            end
            S_DRAIN: if (xfer && is_term) state_d = S_OUT;
            S_CONV:  if (conv_done)       state_d = S_OUT;
            S_OUT:   if (o_ready)         state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == S_IDLE) || (state_q == S_INT) ||
                     (state_q == S_FRAC) || (state_q == S_DRAIN);
        o_valid    = state_q == S_OUT;
        conv_start = xfer && is_term &&
                     ((state_q == S_INT) || (state_q == S_FRAC));
        frac_acc   = xfer && is_digit && (state_q == S_FRAC);
        zero_r     = xfer && is_term && (state_q == S_DRAIN);
    end

    always_comb begin
        int_d  = int_q;
        sign_d = sign_q;
        ovf_d  = ovf_q;
        err_d  = err_q;
        if (hs) begin
            int_d  = '0;
            sign_d = 1'b0;
            ovf_d  = 1'b0;
            err_d  = 1'b0;
        end else if (xfer) begin
            // int_q is zero in IDLE, so the first digit uses the same path
            if (is_digit && ((state_q == S_IDLE) || (state_q == S_INT))) begin
                int_d = prod_ovf ? '1 : prod[int_len-1:0];
                if (prod_ovf) ovf_d = 1'b1;
            end
            if (is_minus && (state_q == S_IDLE)) sign_d = 1'b1;
            if (is_term && (state_q == S_DRAIN)) begin
                err_d = 1'b1;
                int_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_q  <= '0;
            sign_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            int_q  <= int_d;
            sign_q <= sign_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    frac_radix_converter #(
        .fra_len        (fra_len),
        .max_frac_digits(max_frac_digits)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .clear_i (hs),
        .zero_r_i(zero_r),
        .acc_i   (frac_acc),
        .digit_i (in_data[3:0]),
        .start_i (conv_start),
        .full_o  (frac_full),
        .done_o  (conv_done),
        .frac_o  (o_fraction)
    );

    assign o_integer = int_q;
    assign o_sign    = sign_q;
    assign o_error   = ovf_q | err_q;

endmodule

// File: tb/tb_ascii_fixed_point_parser.sv
// Directed and random character streams checked against a string-level
// arithmetic model of the number syntax.
module tb_ascii_fixed_point_parser;

    localparam int IL = 8;
    localparam int FL = 8;
    localparam int MD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'h00;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic [IL-1:0] o_integer;
    logic [FL-1:0] o_fraction;
    logic          o_sign;
    logic          o_error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int term_cyc = 0;
    int numidx = 0;

    ascii_fixed_point_parser #(
        .int_len(IL), .fra_len(FL), .max_frac_digits(MD)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_integer(o_integer), .o_fraction(o_fraction),
        .o_sign(o_sign), .o_error(o_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: scan the string, integer saturates, fraction = floor(R*2^FL/10^nd)
    function automatic void model(input string s, output longint iv,
                                  output longint fr, output bit sg,
                                  output bit er, output bit dr);
        int     phase = 0;
        longint r = 0;
        longint pw = 1;
        int     nd = 0;
        bit     sat = 0;
        byte    c;
        iv = 0; sg = 0; dr = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (phase == 3) begin
                if (c == 8'h0A || c == 8'h20) break;
            end else if (phase == 0) begin
                if (c == 8'h0A || c == 8'h20) continue;
                if (c == "-") begin sg = 1; phase = 1; end
                else if (c >= "0" && c <= "9") begin iv = c - "0"; phase = 1; end
                else if (c == ".") phase = 2;
                else phase = 3;
            end else if (c == 8'h0A || c == 8'h20) begin
                break;
            end else if (phase == 1) begin
                if (c >= "0" && c <= "9") begin
                    iv = iv * 10 + (c - "0");
                    if (iv > 255) begin iv = 255; sat = 1; end
                end else if (c == ".") phase = 2;
                else phase = 3;
            end else begin
                if (c >= "0" && c <= "9") begin
                    if (nd < MD) begin r = r * 10 + (c - "0"); pw = pw * 10; nd++; end
                end else phase = 3;
            end
        end
        if (phase == 3) begin
            iv = 0; fr = 0; er = 1; dr = 1;
        end else begin
            fr = (r << FL) / pw;
            er = sat;
        end
    endfunction

    task automatic send_char(input byte c);
        int n = 0;
        in_valid = 1'b1;
        in_data = c;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        term_cyc = cyc;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_out(input string tag, input int exp_lat);
        int n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("%s latency", tag), 32'(cyc - term_cyc), 32'(exp_lat));
        chk($sformatf("%s valid", tag), 32'(o_valid), 32'd1);
    endtask

    task automatic expect_num(input string s, input int hold);
        longint iv, fr;
        bit sg, er, dr;
        string tag;
        logic [19:0] cap;
        numidx++;
        tag = $sformatf("num%0d", numidx);
        model(s, iv, fr, sg, er, dr);
        send_str(s);
        wait_out(tag, dr ? 0 : FL);
        chk({tag, " integer"}, 32'(o_integer), 32'(iv));
        chk({tag, " fraction"}, 32'(o_fraction), 32'(fr));
        chk({tag, " sign"}, 32'(o_sign), 32'(sg));
        chk({tag, " error"}, 32'(o_error), 32'(er));
        cap = {1'b1, 1'b0, o_sign, o_error, o_integer, o_fraction};
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, " hold"},
                32'({o_valid, in_ready, o_sign, o_error, o_integer, o_fraction}),
                32'(cap));
        end
        o_ready = 1'b1;
        chk({tag, " hs in_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk({tag, " post valid"}, 32'(o_valid), 32'd0);
        chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    endtask

    function automatic string gen();
        string s = "";
        string bad = "a-.x";
        int nl = $urandom_range(0, 2);
        int b;
        for (int i = 0; i < nl; i++) s = {s, " "};
        b = s.len();
        if ($urandom_range(0, 2) == 0) s = {s, "-"};
        for (int i = 0; i < $urandom_range(0, 4); i++)
            s = $sformatf("%s%c", s, 8'(8'h30 + $urandom_range(0, 9)));
        if ($urandom_range(0, 1) == 1) begin
            s = {s, "."};
            for (int i = 0; i < $urandom_range(0, 6); i++)
                s = $sformatf("%s%c", s, 8'(8'h30 + $urandom_range(0, 9)));
        end
        if ($urandom_range(0, 7) == 0)
            s = $sformatf("%s%c", s, bad[$urandom_range(0, 3)]);
        if (s.len() == b) s = {s, "5"};
        s = $sformatf("%s%c", s, $urandom_range(0, 1) == 1 ? 8'h0A : 8'h20);
        return s;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset o_valid", 32'(o_valid), 32'd0);
        chk("reset integer", 32'(o_integer), 32'd0);
        chk("reset fraction", 32'(o_fraction), 32'd0);
        chk("reset sign", 32'(o_sign), 32'd0);
        chk("reset error", 32'(o_error), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        expect_num("3.5\n", 2);
        chk("3.5 fraction const", 32'(8'h80), 32'((longint'(5) << FL) / 10));
        expect_num("-12.25 ", 1);
        expect_num("0.1\n", 0);
        expect_num("0.123456\n", 3);
        expect_num("300\n", 1);
        expect_num("1a9\n", 2);

        // backpressure with a waiting character
        send_str("7\n");
        wait_out("bp", FL);
        in_valid = 1'b1;
        in_data = "4";
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp hold", 32'({o_valid, in_ready, o_error, o_integer, o_fraction}),
                32'({1'b1, 1'b0, 1'b0, 8'h07, 8'h00}));
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk("bp in_ready after hs", 32'(in_ready), 32'd1);
        expect_num("4\n", 0);

        expect_num("  -.75\n", 1);
        expect_num("9.9\n", 0);
        expect_num("-\n", 0);
        expect_num(".\n", 0);

        // reset on the 4th conversion cycle
        send_str("5.5\n");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst mid integer", 32'(o_integer), 32'd0);
        chk("rst mid fraction", 32'(o_fraction), 32'd0);
        chk("rst mid sign/err/valid", 32'({o_sign, o_error, o_valid}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst o_valid", 32'(o_valid), 32'd0);
        expect_num("2\n", 0);

        for (int i = 0; i < 40; i++) expect_num(gen(), $urandom_range(0, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
